rob_commit_unit: RTL
====================

Name: rob_commit_unit

Overview:
- Circular reorder buffer that allocates an entry per issued instruction and collects results from ALU and LSB writeback.
- Commits one entry per cycle in program order to the register file commit port and to the LSB store-commit port.
- Detects branch mispredicts at commit and drives the global flush (clr) with the redirect PC.
- Sits directly upstream of the regfile commit port; its tags are the ROB positions the regfile tracks.

Parameters:
- ROB_SIZE, 16, number of entries; must be a power of two.
- ROB_POS_W, 5, tag width, log2(ROB_SIZE)+1. Tag = slot index + 1, and tag 0 means "no producer / value ready".

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; state frozen when low
rob_full  out  1  no free entry (count == ROB_SIZE)
rob_next_tag  out  ROB_POS_W  tag the next issued instruction will receive (tail+1)
issue_en  in  1  allocate entry at tail
issue_rd  in  5  destination register (0 = none)
issue_is_branch  in  1  entry is a conditional branch
issue_is_store  in  1  entry is a store
issue_pred_taken  in  1  predictor decision
issue_ready  in  1  value already known at issue (lui/auipc/jal link)
issue_val  in  32  value when issue_ready
alu_en  in  1  ALU result valid
alu_tag  in  ROB_POS_W  ALU result tag
alu_val  in  32  ALU result
alu_taken  in  1  branch outcome
alu_target  in  32  correct next PC for branch (taken target or pc+4)
lsb_en  in  1  LSB result valid (load data or store address done)
lsb_tag  in  ROB_POS_W  LSB result tag
lsb_val  in  32  load data
rs1_query_tag, rs2_query_tag  in  ROB_POS_W  operand producer tags from regfile
rs1_query_ready, rs2_query_ready  out  1  producer result available
rs1_query_val, rs2_query_val  out  32  producer result
rob_to_reg_enable  out  1  commit pulse to regfile
rob_to_reg_rd  out  5  committed rd
rob_to_reg_rob_pos  out  ROB_POS_W  committed tag
rob_to_reg_val  out  32  committed value
rob_to_lsb_store_en  out  1  store at head may write memory
rob_to_lsb_store_tag  out  ROB_POS_W  that store's tag
clr  out  1  flush pulse
clr_pc  out  32  redirect PC

Behaviour:
- Entry fields: busy, ready, rd, val, is_branch, is_store, pred_taken, taken, target. Pointers head and tail are log2(ROB_SIZE) bits and wrap modulo ROB_SIZE. count is log2(ROB_SIZE)+1 bits.
- Reset: head = tail = count = 0, all busy = 0. Every output is 0, except rob_next_tag = 1 and rob_full = 0.
- rdy low: no state change; all pulse outputs (rob_to_reg_enable, rob_to_lsb_store_en, clr) are 0 on the next edge.
- Issue: on an edge with issue_en && !rob_full, write the entry at tail and set busy = 1, ready = issue_ready, val = issue_val. Then tail++. issue_en while rob_full is ignored; the issuer must not do this.
- Writeback: alu_en/lsb_en set ready and val of slot tag-1; alu also latches taken and target. Both in the same cycle to different tags are both applied. Writeback to a non-busy slot is ignored.
- Query (combinational):
  - ready = entry ready, OR alu_en && alu_tag == q, OR lsb_en && lsb_tag == q.
  - Bypass priority: alu, then lsb, then stored value.
  - Tag 0 gives ready = 0, val = 0.
- Commit: at most one per edge, when the head entry is busy and ready. Outputs are registered and valid for exactly one cycle.
  - Non-store, non-branch: rob_to_reg_enable = 1 with rd, tag, val. rd = 0 still pulses; the regfile ignores it.
  - Store: the store is ready once lsb_en has reported it. Assert rob_to_lsb_store_en with its tag, no reg commit, and free the entry.
  - Branch: no reg commit. If taken != pred_taken, assert clr = 1 and clr_pc = target.
  - On the commit edge that raises clr, all entries are cleared and head = tail = count = 0. Issue and writeback on that same edge are discarded.
- Commit latency: an entry that becomes ready via writeback at edge N commits at edge N+1 at the earliest. Outputs appear after edge N+1. An issue_ready entry at head commits on the edge after issue.
- Simultaneous issue and commit: count unchanged, and both take effect. When full, commit frees a slot; rob_full drops the following cycle (registered count).
- Wrap-around: tag ROB_SIZE follows tag ROB_SIZE-1, and tag 1 follows tag ROB_SIZE. Tag 0 is never allocated.
- rst asserted mid-operation overrides everything on that edge.

Test Plan:
- Reset, then issue 3 ALU ops (rd = 1, 2, 3) with tags 1, 2, 3. Write back tag 2 val 0x22, then tag 1 val 0x11, then tag 3 val 0x33 → commits in order rd1/0x11, rd2/0x22, rd3/0x33 on consecutive cycles.
- Issue 16 entries → rob_full = 1. Issue_en on the 17th cycle is ignored. After one commit, rob_full = 0 next cycle. The next issue gets tag 1 (wrap).
- Branch at tag 1 with pred_taken = 0, alu_taken = 1, alu_target = 0x100; younger entries at tags 2 and 3 → clr pulses one cycle with clr_pc = 0x100. rob_next_tag returns to 1 and tags 2 and 3 never commit.
- Query rs1_query_tag = 4 in the same cycle alu_en writes tag 4 val 0xABCD → rs1_query_ready = 1, rs1_query_val = 0xABCD combinationally.
- Store at head, lsb_en tag matches → rob_to_lsb_store_en = 1 with tag, rob_to_reg_enable = 0. Hold rdy = 0 for 3 cycles before it → no commit until rdy returns.
- Assert rst while 5 entries are in flight → the next cycle shows count 0, rob_full = 0, no pulses, rob_next_tag = 1.

Source files
------------

// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order commit.
// Entries are allocated at the tail when instructions issue. Results arrive
// from the ALU and LSB writeback buses. The entry at the head retires one per
// cycle to the regfile or to the LSB store port. A mispredicted branch at
// commit flushes the whole buffer.
// Tags are slot index + 1, so tag 0 is free to mean "no producer".
// All commit-side outputs are registered one-cycle pulses. Their payloads read
// zero whenever the matching pulse is low.
// When rdy is low, no state changes and every pulse output goes low.
module rob_commit_unit #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_POS_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  output logic                 rob_full,
  output logic [ROB_POS_W-1:0] rob_next_tag,
  input  logic                 issue_en,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_is_branch,
  input  logic                 issue_is_store,
  input  logic                 issue_pred_taken,
  input  logic                 issue_ready,
  input  logic [31:0]          issue_val,
  input  logic                 alu_en,
  input  logic [ROB_POS_W-1:0] alu_tag,
  input  logic [31:0]          alu_val,
  input  logic                 alu_taken,
  input  logic [31:0]          alu_target,
  input  logic                 lsb_en,
  input  logic [ROB_POS_W-1:0] lsb_tag,
  input  logic [31:0]          lsb_val,
  input  logic [ROB_POS_W-1:0] rs1_query_tag,
  input  logic [ROB_POS_W-1:0] rs2_query_tag,
  output logic                 rs1_query_ready,
  output logic                 rs2_query_ready,
  output logic [31:0]          rs1_query_val,
  output logic [31:0]          rs2_query_val,
  output logic                 rob_to_reg_enable,
  output logic [4:0]           rob_to_reg_rd,
  output logic [ROB_POS_W-1:0] rob_to_reg_rob_pos,
  output logic [31:0]          rob_to_reg_val,
  output logic                 rob_to_lsb_store_en,
  output logic [ROB_POS_W-1:0] rob_to_lsb_store_tag,
  output logic                 clr,
  output logic [31:0]          clr_pc
);
  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam logic [ROB_POS_W-1:0] MAX_TAG = ROB_POS_W'(ROB_SIZE);

  // Entry storage
  logic        busy_q      [ROB_SIZE];
  logic        ready_q     [ROB_SIZE];
  logic [4:0]  rd_q        [ROB_SIZE];
  logic [31:0] val_q       [ROB_SIZE];
  logic        is_branch_q [ROB_SIZE];
  logic        is_store_q  [ROB_SIZE];
  logic        pred_q      [ROB_SIZE];
  logic        taken_q     [ROB_SIZE];
  logic [31:0] target_q    [ROB_SIZE];

  logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [ROB_POS_W-1:0] count_q, count_d;

  // Registered commit-side outputs
  logic                 reg_en_q, st_en_q, clr_q;
  logic [4:0]           reg_rd_q;
  logic [ROB_POS_W-1:0] reg_pos_q, st_tag_q;
  logic [31:0]          reg_val_q, clr_pc_q;

  logic full_w, commit_fire, flush, issue_fire;
  logic alu_hit, lsb_hit;
  logic [IDX_W-1:0] alu_idx, lsb_idx;

  function automatic logic [IDX_W-1:0] tag_to_idx(input logic [ROB_POS_W-1:0] tag);
    logic [ROB_POS_W-1:0] m1;
    m1 = tag - ROB_POS_W'(1);
    return m1[IDX_W-1:0];
  endfunction

  function automatic logic tag_ok(input logic [ROB_POS_W-1:0] tag);
    return (tag != '0) && (tag <= MAX_TAG);
  endfunction

  function automatic logic [ROB_POS_W-1:0] idx_to_tag(input logic [IDX_W-1:0] idx);
    return ROB_POS_W'(idx) + ROB_POS_W'(1);
  endfunction

  // Operand lookup. The bypass order is ALU bus, then LSB bus, then the stored entry.
  // The result is {ready, value}.
  function automatic logic [32:0] lookup(input logic [ROB_POS_W-1:0] tag);
    logic [32:0]      res;
    logic [IDX_W-1:0] idx;
    res = '0;
    idx = tag_to_idx(tag);
    if (tag != '0) begin
      if (alu_en && (alu_tag == tag))      res = {1'b1, alu_val};
      else if (lsb_en && (lsb_tag == tag)) res = {1'b1, lsb_val};
      else if (tag_ok(tag))                res = {busy_q[idx] && ready_q[idx], val_q[idx]};
    end
    return res;
  endfunction

  // Combinational operand queries for the two source registers
  always_comb begin
    {rs1_query_ready, rs1_query_val} = lookup(rs1_query_tag);
    {rs2_query_ready, rs2_query_val} = lookup(rs2_query_tag);
  end

  // Decide this cycle's commit, flush, issue and writeback, and the next pointer values
  always_comb begin
    full_w      = (count_q == MAX_TAG);
    commit_fire = rdy && busy_q[head_q] && ready_q[head_q];
    flush       = commit_fire && is_branch_q[head_q] && (taken_q[head_q] != pred_q[head_q]);
    issue_fire  = rdy && !flush && issue_en && !full_w;
    alu_idx     = tag_to_idx(alu_tag);
    lsb_idx     = tag_to_idx(lsb_tag);
    alu_hit     = rdy && !flush && alu_en && tag_ok(alu_tag) && busy_q[alu_idx];
    lsb_hit     = rdy && !flush && lsb_en && tag_ok(lsb_tag) && busy_q[lsb_idx];
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (commit_fire) head_d = head_q + IDX_W'(1);
      if (issue_fire)  tail_d = tail_q + IDX_W'(1);
      count_d = count_q + ROB_POS_W'(issue_fire) - ROB_POS_W'(commit_fire);
    end
  end

  // Pointer registers and registered commit/flush pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      reg_en_q  <= 1'b0;
      reg_rd_q  <= '0;
      reg_pos_q <= '0;
      reg_val_q <= '0;
      st_en_q   <= 1'b0;
      st_tag_q  <= '0;
      clr_q     <= 1'b0;
      clr_pc_q  <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      reg_en_q  <= 1'b0;
      reg_rd_q  <= '0;
      reg_pos_q <= '0;
      reg_val_q <= '0;
      st_en_q   <= 1'b0;
      st_tag_q  <= '0;
      clr_q     <= 1'b0;
      clr_pc_q  <= '0;
      if (flush) begin
        clr_q    <= 1'b1;
        clr_pc_q <= target_q[head_q];
      end else if (commit_fire) begin
        if (is_store_q[head_q]) begin
          st_en_q  <= 1'b1;
          st_tag_q <= idx_to_tag(head_q);
        end else if (!is_branch_q[head_q]) begin
          reg_en_q  <= 1'b1;
          reg_rd_q  <= rd_q[head_q];
          reg_pos_q <= idx_to_tag(head_q);
          reg_val_q <= val_q[head_q];
        end
      end
    end
  end

  // Entry updates: writeback first, then commit frees the head, then issue fills the tail
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy_q[i]      <= 1'b0;
        ready_q[i]     <= 1'b0;
        rd_q[i]        <= '0;
        val_q[i]       <= '0;
        is_branch_q[i] <= 1'b0;
        is_store_q[i]  <= 1'b0;
        pred_q[i]      <= 1'b0;
        taken_q[i]     <= 1'b0;
        target_q[i]    <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < ROB_SIZE; i++) busy_q[i] <= 1'b0;
    end else begin
      if (alu_hit) begin
        ready_q[alu_idx]  <= 1'b1;
        val_q[alu_idx]    <= alu_val;
        taken_q[alu_idx]  <= alu_taken;
        target_q[alu_idx] <= alu_target;
      end
      if (lsb_hit) begin
        ready_q[lsb_idx] <= 1'b1;
        val_q[lsb_idx]   <= lsb_val;
      end
      if (commit_fire) busy_q[head_q] <= 1'b0;
      if (issue_fire) begin
        busy_q[tail_q]      <= 1'b1;
        ready_q[tail_q]     <= issue_ready;
        rd_q[tail_q]        <= issue_rd;
        val_q[tail_q]       <= issue_val;
        is_branch_q[tail_q] <= issue_is_branch;
        is_store_q[tail_q]  <= issue_is_store;
        pred_q[tail_q]      <= issue_pred_taken;
        taken_q[tail_q]     <= 1'b0;
        target_q[tail_q]    <= '0;
      end
    end
  end

  assign rob_full             = (count_q == MAX_TAG);
  assign rob_next_tag         = idx_to_tag(tail_q);
  assign rob_to_reg_enable    = reg_en_q;
  assign rob_to_reg_rd        = reg_rd_q;
  assign rob_to_reg_rob_pos   = reg_pos_q;
  assign rob_to_reg_val       = reg_val_q;
  assign rob_to_lsb_store_en  = st_en_q;
  assign rob_to_lsb_store_tag = st_tag_q;
  assign clr                  = clr_q;
  assign clr_pc               = clr_pc_q;

endmodule
